// File: rtl/main_mem_responder.sv
// main_mem_responder: single-outstanding main-memory model below the L2.
// Fixed read/write latency, written-bit per line so unwritten lines read as zero.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif
module main_mem_responder #(
   parameter int MEM_IDX_BITS  = 10,
   parameter int READ_LATENCY  = 20,
   parameter int WRITE_LATENCY = 20
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 mem_req_valid,
   output logic                                 mem_req_ready,
   input  logic                                 mem_req_rw,
   input  logic [`ADDR_BITS-`OFFSET_BITS-1:0]   mem_req_addr,
   input  logic [`CACHELINE_BITS-1:0]           mem_req_data,
   output logic                                 mem_resp_valid,
   output logic [`CACHELINE_BITS-1:0]           mem_resp_data
);
   localparam int AW    = `ADDR_BITS - `OFFSET_BITS;
   localparam int CL    = `CACHELINE_BITS;
   localparam int DEPTH = 1 << MEM_IDX_BITS;
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0]              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [DEPTH-1:0]        written_q, written_d;
   logic [CL-1:0]           line_q, line_d, data_q, data_d;
   logic [CL-1:0]           mem_q [DEPTH];
   logic [MEM_IDX_BITS-1:0] idx;
   logic [7:0]              lat_m1;
   logic [CL-1:0]           rd_line;
   logic                    accept, unused_addr;
   assign idx            = mem_req_addr[MEM_IDX_BITS-1:0];
   assign unused_addr    = ^mem_req_addr[AW-1:MEM_IDX_BITS];
   assign mem_req_ready  = state_q == IDLE;
   assign mem_resp_valid = state_q == RESP;
   assign mem_resp_data  = data_q;
   assign accept         = mem_req_valid && mem_req_ready;
   assign lat_m1         = mem_req_rw ? 8'(WRITE_LATENCY - 1) : 8'(READ_LATENCY - 1);
   // a write response echoes the incoming line, which also commits at this edge
   assign rd_line        = mem_req_rw ? mem_req_data : (written_q[idx] ? mem_q[idx] : '0);
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      written_d = written_q;
      line_d    = line_q;
      if (accept) begin
         line_d  = rd_line;
         cnt_d   = lat_m1;
         state_d = lat_m1 != 8'd0 ? WAIT : RESP;
         if (mem_req_rw) written_d[idx] = 1'b1;
      end else if (state_q == WAIT) begin
         cnt_d   = cnt_q - 8'd1;
         state_d = cnt_q == 8'd1 ? RESP : WAIT;
      end else if (state_q != IDLE) begin
         state_d = IDLE;
      end
      // output only changes when a response is presented
      data_d = state_d == RESP ? (accept ? rd_line : line_q) : data_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         written_q <= '0;
         line_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         written_q <= written_d;
         line_q    <= line_d;
         data_q    <= data_d;
      end
   end
   always_ff @(posedge clk) begin
      if (accept && mem_req_rw) mem_q[idx] <= mem_req_data;
   end
endmodule
